// File: rtl/mem_arbiter_if.sv
// Fetch, LSU and memory-port signal bundle for mem_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  lsu_req;
    logic                  lsu_we;
    logic [1:0]            lsu_size;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic                  lsu_gnt;
    logic                  lsu_rvalid;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  lsu_misaligned;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W/8-1:0]   mem_be;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_misaligned,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_misaligned,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter/sequencer between fetch, LSU and a shared memory port.
// Define MEM_ARB_FAIRNESS_EN for round-robin tie-breaking; default is LSU-over-fetch.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         stall
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
    typedef enum logic {OWN_FETCH, OWN_LSU} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                lsu_rvalid_q, lsu_rvalid_d;

    logic                if_gnt_c, lsu_gnt_c, misaligned_c;
    logic                prefer_lsu, lsu_wins, lsu_misal;
    logic [1:0]          lsu_off;
    logic [BE_W-1:0]     lsu_be;
    logic [DATA_W-1:0]   lsu_wlanes;

    assign lsu_off = bus.lsu_addr[1:0];

    // Size/offset decode: lane enables, lane-replicated store data, alignment check
    always_comb begin
        lsu_be     = '0;
        lsu_wlanes = bus.lsu_wdata;
        lsu_misal  = 1'b0;
        case (bus.lsu_size)
            2'd0: begin
                lsu_be     = BE_W'(4'b0001 << lsu_off);
                lsu_wlanes = DATA_W'({4{bus.lsu_wdata[7:0]}});
            end
            2'd1: begin
                lsu_be     = BE_W'(4'b0011 << lsu_off);
                lsu_wlanes = DATA_W'({2{bus.lsu_wdata[15:0]}});
                lsu_misal  = lsu_off[0];
            end
            2'd2: begin
                lsu_be    = BE_W'(4'b1111);
                lsu_misal = (lsu_off != 2'd0);
            end
            default: lsu_misal = 1'b1;
        endcase
    end

`ifdef MEM_ARB_FAIRNESS_EN
    logic prefer_lsu_q, prefer_lsu_d;

    // The requester just served yields the next tie
    always_comb begin
        prefer_lsu_d = prefer_lsu_q;
        if (lsu_gnt_c)     prefer_lsu_d = 1'b0;
        else if (if_gnt_c) prefer_lsu_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prefer_lsu_q <= 1'b1;
        else     prefer_lsu_q <= prefer_lsu_d;
    end

    assign prefer_lsu = prefer_lsu_q;
`else
    assign prefer_lsu = 1'b1;
`endif

    assign lsu_wins = bus.lsu_req & (~bus.if_req | prefer_lsu);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        if_rvalid_d  = 1'b0;
        lsu_rvalid_d = 1'b0;
        if_gnt_c     = 1'b0;
        lsu_gnt_c    = 1'b0;
        misaligned_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_wins) begin
                    lsu_gnt_c = 1'b1;
                    if (lsu_misal) begin
                        misaligned_c = 1'b1;
                    end else begin
                        state_d = REQ;
                        owner_d = OWN_LSU;
                        we_d    = bus.lsu_we;
                        be_d    = lsu_be;
                        addr_d  = bus.lsu_addr & ~ADDR_W'(3);
                        wdata_d = lsu_wlanes;
                    end
                end else if (bus.if_req) begin
                    if_gnt_c = 1'b1;
                    state_d  = REQ;
                    owner_d  = OWN_FETCH;
                    we_d     = 1'b0;
                    be_d     = '1;
                    addr_d   = bus.if_addr & ~ADDR_W'(3);
                    wdata_d  = '0;
                end
            end
            REQ: begin
                if (bus.mem_gnt) state_d = RSP;
            end
            RSP: begin
                if (bus.mem_rvalid) begin
                    state_d      = IDLE;
                    rdata_d      = bus.mem_rdata;
                    if_rvalid_d  = (owner_q == OWN_FETCH);
                    lsu_rvalid_d = (owner_q == OWN_LSU);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_LSU;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            if_rvalid_q  <= 1'b0;
            lsu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            if_rvalid_q  <= if_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
        end
    end

    // Grant pulses are combinational; masked so reset forces every output low at once
    assign bus.if_gnt         = if_gnt_c & ~rst;
    assign bus.lsu_gnt        = lsu_gnt_c & ~rst;
    assign bus.lsu_misaligned = misaligned_c & ~rst;
    assign bus.if_rvalid      = if_rvalid_q;
    assign bus.if_rdata       = rdata_q;
    assign bus.lsu_rvalid     = lsu_rvalid_q;
    assign bus.lsu_rdata      = rdata_q;
    assign bus.mem_req        = (state_q == REQ);
    assign bus.mem_we         = we_q;
    assign bus.mem_be         = be_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = wdata_q;

    assign stall = ~rst & ((bus.if_req & ~if_gnt_c) | (bus.lsu_req & ~lsu_gnt_c) |
                           (state_q != IDLE) | if_rvalid_q | lsu_rvalid_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the grant/memory/delivery rules and a word memory.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk;
    logic rst;
    logic stall;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one transaction in flight, its memory phase, and a pending delivery
    bit          inflight, mreq_exp, rsp_exp, dlv_exp, dlv_lsu, dlv_we;
    bit          pref_lsu, if_wait, lsu_wait, t_we, t_lsu;
    logic [31:0] dlv_data, t_addr, t_wdata;
    logic [3:0]  t_be;
    logic [31:0] mem_words [int unsigned];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Bytes [off, off+n) are enabled; lane i carries source byte (i mod n)
    function automatic void lsu_xlate(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] wd, output logic [3:0] be,
                                      output logic [31:0] wl, output bit mis);
        int n;
        int off;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = (size == 2'd3) || ((off % n) != 0);
        be  = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + n) be[i] = 1'b1;
            wl[8*i +: 8] = wd[8*(i % n) +: 8];
        end
    endfunction

    // Check one clock cycle against the model, then advance model and clock
    task automatic cycle();
        logic        eg_if, eg_lsu, e_mis, e_stall;
        logic [3:0]  be;
        logic [31:0] wl, w;
        bit          mis, next_dlv;
        #1;
        eg_if  = 1'b0;
        eg_lsu = 1'b0;
        e_mis  = 1'b0;
        lsu_xlate(bus.lsu_size, bus.lsu_addr, bus.lsu_wdata, be, wl, mis);
        if (!inflight && (bus.lsu_req || bus.if_req)) begin
            if (bus.lsu_req && (!bus.if_req || pref_lsu)) begin
                eg_lsu = 1'b1;
                e_mis  = mis;
            end else begin
                eg_if = 1'b1;
            end
        end
        e_stall = (bus.if_req && !eg_if) || (bus.lsu_req && !eg_lsu) || inflight || dlv_exp;
        chk("if_gnt", bus.if_gnt, eg_if);
        chk("lsu_gnt", bus.lsu_gnt, eg_lsu);
        chk("lsu_misaligned", bus.lsu_misaligned, e_mis);
        chk("stall", stall, e_stall);
        chk("mem_req", bus.mem_req, mreq_exp);
        if (mreq_exp) begin
            chk("mem_addr", bus.mem_addr, t_addr);
            chk("mem_be", bus.mem_be, t_be);
            chk("mem_we", bus.mem_we, t_we);
            if (t_we) chk("mem_wdata", bus.mem_wdata, t_wdata);
        end
        chk("if_rvalid", bus.if_rvalid, dlv_exp && !dlv_lsu);
        chk("lsu_rvalid", bus.lsu_rvalid, dlv_exp && dlv_lsu);
        if (dlv_exp && !dlv_we) begin
            if (dlv_lsu) chk("lsu_rdata", bus.lsu_rdata, dlv_data);
            else         chk("if_rdata", bus.if_rdata, dlv_data);
        end

        if (dlv_exp) begin
            if (dlv_lsu) lsu_wait = 1'b0;
            else         if_wait  = 1'b0;
        end
        next_dlv = 1'b0;
        if (rsp_exp && bus.mem_rvalid) begin
            next_dlv = 1'b1;
            dlv_data = bus.mem_rdata;
            dlv_lsu  = t_lsu;
            dlv_we   = t_we;
            if (t_we) begin
                w = rd_word(t_addr);
                for (int i = 0; i < 4; i++) if (t_be[i]) w[8*i +: 8] = t_wdata[8*i +: 8];
                mem_words[t_addr] = w;
            end
            inflight = 1'b0;
            rsp_exp  = 1'b0;
        end else if (mreq_exp && bus.mem_gnt) begin
            mreq_exp = 1'b0;
            rsp_exp  = 1'b1;
        end
        dlv_exp = next_dlv;
        if (eg_lsu) begin
`ifdef MEM_ARB_FAIRNESS_EN
            pref_lsu = 1'b0;
`endif
            if (!e_mis) begin
                t_addr   = bus.lsu_addr & 32'hFFFF_FFFC;
                t_be     = be;
                t_we     = bus.lsu_we;
                t_wdata  = wl;
                t_lsu    = 1'b1;
                inflight = 1'b1;
                mreq_exp = 1'b1;
                lsu_wait = 1'b1;
            end
        end
        if (eg_if) begin
`ifdef MEM_ARB_FAIRNESS_EN
            pref_lsu = 1'b1;
`endif
            t_addr   = bus.if_addr & 32'hFFFF_FFFC;
            t_be     = 4'hF;
            t_we     = 1'b0;
            t_wdata  = '0;
            t_lsu    = 1'b0;
            inflight = 1'b1;
            mreq_exp = 1'b1;
            if_wait  = 1'b1;
        end

        @(posedge clk);
        #2;
        if (eg_if)  bus.if_req  = 1'b0;
        if (eg_lsu) bus.lsu_req = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_if_gnt", bus.if_gnt, 0);
        chk("rst_if_rvalid", bus.if_rvalid, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_lsu_gnt", bus.lsu_gnt, 0);
        chk("rst_lsu_rvalid", bus.lsu_rvalid, 0);
        chk("rst_lsu_rdata", bus.lsu_rdata, 0);
        chk("rst_lsu_misaligned", bus.lsu_misaligned, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_stall", stall, 0);
        inflight = 1'b0; mreq_exp = 1'b0; rsp_exp = 1'b0; dlv_exp = 1'b0;
        pref_lsu = 1'b1; if_wait = 1'b0; lsu_wait = 1'b0;
        bus.if_req = 1'b0; bus.lsu_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic lsu_set(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd);
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = we;
        bus.lsu_size  = size;
        bus.lsu_addr  = addr;
        bus.lsu_wdata = wd;
    endtask

    task automatic auto_mem(input int unsigned pg, input int unsigned pr, input int unsigned spur);
        bus.mem_gnt    = mreq_exp ? ($urandom_range(0, 99) < pg) : ($urandom_range(0, 99) < spur);
        bus.mem_rvalid = rsp_exp  ? ($urandom_range(0, 99) < pr) : ($urandom_range(0, 99) < spur);
        bus.mem_rdata  = (rsp_exp && !t_we) ? rd_word(t_addr) : $urandom();
    endtask

    task automatic drain();
        int n = 0;
        while ((inflight || dlv_exp || bus.if_req || bus.lsu_req) && n < 100) begin
            auto_mem(100, 100, 0);
            cycle();
            n++;
        end
        chk("drain_done", 32'(n < 100), 1);
    endtask

    task automatic rand_req();
        if (!bus.if_req && !if_wait && $urandom_range(0, 2) == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = {24'h0, 8'($urandom())};
        end
        if (!bus.lsu_req && !lsu_wait && $urandom_range(0, 2) == 0)
            lsu_set(1'($urandom()), 2'($urandom()), {24'h0, 8'($urandom())}, $urandom());
    endtask

    initial begin
        logic [1:0]  mis_size [3];
        logic [31:0] mis_addr [3];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_size = '0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        do_reset();

        // Fetch read with immediate memory grant
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        #1; chk("t1_if_gnt", bus.if_gnt, 1);
        cycle();
        bus.mem_gnt = 1'b1;
        #1; chk("t1_mem_addr", bus.mem_addr, 32'h1000); chk("t1_mem_be", bus.mem_be, 4'hF);
        chk("t1_stall_req", stall, 1);
        cycle();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        cycle();
        #1; chk("t1_if_rvalid", bus.if_rvalid, 1); chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("t1_stall_dlv", stall, 1);
        cycle();
        #1; chk("t1_stall_after", stall, 0);
        cycle();

        // Byte store with 4 cycles of memory back-pressure and a stray mem_rvalid
        lsu_set(1'b1, 2'd0, 32'h2003, 32'h0000_00AB);
        #1; chk("t2_lsu_gnt", bus.lsu_gnt, 1);
        cycle();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) bus.mem_rvalid = 1'b1;
            #1;
            chk("t2_mem_req", bus.mem_req, 1);
            chk("t2_mem_addr", bus.mem_addr, 32'h2000);
            chk("t2_mem_be", bus.mem_be, 4'b1000);
            chk("t2_mem_wdata", bus.mem_wdata, 32'hABABABAB);
            chk("t2_stall", stall, 1);
            cycle();
        end
        bus.mem_gnt = 1'b1; cycle();
        cycle();
        bus.mem_rvalid = 1'b1; cycle();
        #1; chk("t2_lsu_rvalid", bus.lsu_rvalid, 1);
        cycle();

        // Aligned halfword store in the upper half
        lsu_set(1'b1, 2'd1, 32'h2002, 32'h1234_CDEF);
        cycle();
        #1; chk("t2h_mem_be", bus.mem_be, 4'b1100); chk("t2h_mem_wdata", bus.mem_wdata, 32'hCDEFCDEF);
        drain();

        // Tie: LSU first, fetch granted in the LSU delivery cycle
        bus.if_req = 1'b1; bus.if_addr = 32'h3000;
        lsu_set(1'b0, 2'd2, 32'h3004, 32'h0);
        #1; chk("t3_lsu_first", bus.lsu_gnt, 1); chk("t3_if_wait", bus.if_gnt, 0);
        cycle();
        bus.mem_gnt = 1'b1; cycle();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222; cycle();
        #1; chk("t3_lsu_rvalid", bus.lsu_rvalid, 1); chk("t3_lsu_rdata", bus.lsu_rdata, 32'h1111_2222);
        chk("t3_if_gnt", bus.if_gnt, 1);
        cycle();
        drain();

        // Back-to-back LSU against a waiting fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h3100;
        lsu_set(1'b0, 2'd2, 32'h3104, 32'h0);
        #1; chk("t3b_lsu_first", bus.lsu_gnt, 1);
        cycle();
        bus.mem_gnt = 1'b1; cycle();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3333_4444; cycle();
        lsu_set(1'b0, 2'd2, 32'h3108, 32'h0);
        #1;
`ifdef MEM_ARB_FAIRNESS_EN
        chk("t3b_second_tie_fetch", bus.if_gnt, 1);
`else
        chk("t3b_second_tie_lsu", bus.lsu_gnt, 1);
`endif
        cycle();
        drain();

        // Misaligned requests are rejected without a memory transaction
        mis_size = '{2'd2, 2'd1, 2'd3};
        mis_addr = '{32'h2002, 32'h2001, 32'h2000};
        for (int m = 0; m < 3; m++) begin
            lsu_set(1'b0, mis_size[m], mis_addr[m], 32'h0);
            #1; chk("t4_lsu_gnt", bus.lsu_gnt, 1); chk("t4_misaligned", bus.lsu_misaligned, 1);
            chk("t4_mem_req_now", bus.mem_req, 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                #1; chk("t4_mem_req_later", bus.mem_req, 0);
                cycle();
            end
        end

        // Reset while waiting for the response; a late mem_rvalid must be dropped
        bus.if_req = 1'b1; bus.if_addr = 32'h4000;
        cycle();
        bus.mem_gnt = 1'b1; cycle();
        cycle();
        do_reset();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        cycle();
        #1; chk("t5_no_if_rvalid", bus.if_rvalid, 0); chk("t5_no_lsu_rvalid", bus.lsu_rvalid, 0);
        cycle();

        // Random traffic with random back-pressure and stray memory strobes
        for (int c = 0; c < 1500; c++) begin
            rand_req();
            auto_mem(50, 50, 15);
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
